// File: rtl/rf_sequencer.sv
// Frame sequencer for the receptive-field selector: walks every (row, column-half) batch
// of one image and offers each to the conv units over a valid/ready handshake.
module rf_sequencer #(
  parameter int unsigned H = 16,
  parameter int unsigned W = 16,
  parameter int unsigned F = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rf_ready,
  output logic [5:0] row_number,
  output logic [5:0] column,
  output logic [5:0] col_base,
  output logic       rf_valid,
  output logic       rf_last,
  output logic       busy,
  output logic       done,
  output logic [7:0] beat_count
);

  localparam int unsigned Rows = H - F + 1;
  localparam logic [5:0] LastRow = 6'(Rows - 1);
  localparam logic [5:0] HalfBase = 6'((W - F + 1) / 2);

  typedef enum logic [1:0] {StIdle, StSettle, StIssue, StDone} state_e;

  state_e     state_q, state_d;
  logic [5:0] row_q, row_d;
  logic       col_q, col_d;
  logic [7:0] beat_q, beat_d;
  logic       at_last;

  assign at_last = (row_q == LastRow) && col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        row_d = '0;
        col_d = 1'b0;
        if (start) begin
          state_d = StSettle;
          beat_d  = '0;
        end
      end
      StSettle: state_d = StIssue;
      StIssue: begin
        if (rf_ready) begin
          beat_d = beat_q + 8'd1;
          if (at_last) begin
            state_d = StDone;
          end else begin
            state_d = StSettle;
            col_d   = ~col_q;
            if (col_q) row_d = row_q + 6'd1;
          end
        end
      end
      StDone: begin
        // Position is cleared on the way back to IDLE; beat_count holds until next start.
        state_d = StIdle;
        row_d   = '0;
        col_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rf_valid = 1'b0;
    rf_last  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle:   ;
      StSettle: busy = 1'b1;
      StIssue: begin
        busy     = 1'b1;
        rf_valid = 1'b1;
        rf_last  = at_last;
      end
      StDone:   done = 1'b1;
      default:  ;
    endcase
  end

  assign row_number = row_q;
  assign column     = {5'b0, col_q};
  assign col_base   = col_q ? HalfBase : 6'd0;
  assign beat_count = beat_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer: default geometry plus an H=W=8, F=3 instance.
module tb_rf_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;

  logic [5:0] a_row, a_col, a_base, b_row, b_col, b_base;
  logic       a_valid, a_last, a_busy, a_done, b_valid, b_last, b_busy, b_done;
  logic [7:0] a_beat, b_beat;

  logic [5:0] o_row, o_col, o_base;
  logic       o_valid, o_last, o_busy, o_done;
  logic [7:0] o_beat;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  logic [26:0] q[$];

  always #5 clk = ~clk;

  rf_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .rf_ready(ready),
    .row_number(a_row), .column(a_col), .col_base(a_base), .rf_valid(a_valid),
    .rf_last(a_last), .busy(a_busy), .done(a_done), .beat_count(a_beat)
  );

  rf_sequencer #(.H(8), .W(8), .F(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start & sel), .rf_ready(ready),
    .row_number(b_row), .column(b_col), .col_base(b_base), .rf_valid(b_valid),
    .rf_last(b_last), .busy(b_busy), .done(b_done), .beat_count(b_beat)
  );

  always_comb begin
    o_row   = sel ? b_row : a_row;
    o_col   = sel ? b_col : a_col;
    o_base  = sel ? b_base : a_base;
    o_valid = sel ? b_valid : a_valid;
    o_last  = sel ? b_last : a_last;
    o_busy  = sel ? b_busy : a_busy;
    o_done  = sel ? b_done : a_done;
    o_beat  = sel ? b_beat : a_beat;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each accepted batch is compared against the next expected entry.
  always @(negedge clk) begin
    if (o_valid && ready && !reset) begin
      logic [26:0] e;
      hs_cnt++;
      check_eq("q_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check_eq("batch", {5'b0, o_row, o_col, o_base, o_last, o_beat}, {5'b0, e});
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {2'b0, o_row, o_col, o_base, o_valid, o_last, o_busy, o_done, o_beat};
  endfunction

  // stall_k < 0: no stall; reset_at > 0: reset in that cycle and expect no done.
  task automatic run_frame(input bit use_b, input int rows, input int half, input int stall_k,
                           input int stall_len, input bit spur, input int reset_at,
                           input int exp_done);
    int done_cyc = -1;
    int done_cnt = 0;
    int stall_at = (stall_k >= 0) ? 2 + 2 * stall_k : -100;
    int last_n = (reset_at > 0) ? reset_at + 4 : exp_done + 1;
    sel = use_b;
    for (int k = 0; k < 2 * rows; k++) begin
      q.push_back({6'(k / 2), 6'(k % 2), (k % 2 == 1) ? 6'(half) : 6'd0,
                   1'(k == 2 * rows - 1), 8'(k)});
    end
    hs_cnt = 0;
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= last_n; n++) begin
      ready = !(n >= stall_at && n < stall_at + stall_len);
      start = spur && (n == 10 || n == 11);
      reset = (n == reset_at);
      if (n == reset_at) ready = 1'b0;
      @(negedge clk);
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (n >= stall_at && n < stall_at + stall_len)
        check_eq("stall_hold", {25'b0, o_valid, o_row}, {25'b1, 6'(stall_k / 2)});
      if (n >= stall_at && n < stall_at + stall_len)
        check_eq("stall_col", {26'b0, o_col}, 32'(stall_k % 2));
      if (n == stall_at + stall_len + 1)
        check_eq("settle_after_stall", {30'b0, o_valid, o_busy}, 32'b01);
      if (n == stall_at + stall_len + 2)
        check_eq("next_after_stall", {20'b0, o_row, o_col},
                 {20'b0, 6'((stall_k + 1) / 2), 6'((stall_k + 1) % 2)});
      if (reset_at > 0 && n == reset_at + 1)
        check_eq("mid_reset_outs", all_outs(), 32'd0);
      if (reset_at <= 0 && n == exp_done + 1)
        check_eq("idle_after_done", all_outs(), {24'b0, 8'(2 * rows)});
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    start = 1'b0;
    if (reset_at > 0) begin
      check_eq("no_done_on_reset", 32'(done_cnt), 32'd0);
      check_eq("hs_before_reset", 32'(hs_cnt), 32'(2 * (reset_at - 2) / 4 * 2 / 2));
      q.delete();
    end else begin
      check_eq("done_cycle", 32'(done_cyc), 32'(exp_done));
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      check_eq("hs_count", 32'(hs_cnt), 32'(2 * rows));
      check_eq("q_drained", 32'(q.size()), 32'd0);
    end
  endtask

  initial begin
    // start asserted together with reset must not leave IDLE.
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("reset_outs_a", all_outs(), 32'd0);
    sel = 1'b1;
    #1;
    check_eq("reset_outs_b", all_outs(), 32'd0);
    sel = 1'b0;
    @(posedge clk);
    #1;

    run_frame(1'b0, 12, 6, -1, 0, 1'b0, 0, 49);
    run_frame(1'b0, 12, 6, 7, 5, 1'b0, 0, 54);
    run_frame(1'b0, 12, 6, -1, 0, 1'b1, 0, 49);
    // Batch (5,0) is k=10, offered in cycle 22; 10 batches accepted before it.
    run_frame(1'b0, 12, 6, -1, 0, 1'b0, 22, 0);
    run_frame(1'b0, 12, 6, -1, 0, 1'b0, 0, 49);
    run_frame(1'b1, 6, 3, -1, 0, 1'b0, 0, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
